async_fifo_wr_arbiter: RTL and testbench



---
 rtl/async_fifo_wr_arbiter_if.sv | 39 +++
 rtl/async_fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_arbiter_if
// Description : Bundle of producer handshake, FIFO write-side and status
//               signals shared by the write-port arbiter and its neighbours.
//               master : producers / FIFO side (drives req, valid, data,
//                        fifo_full; observes everything else)
//               slave  : the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface async_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 20
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]            ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          busy;
  logic [CNT_W-1:0]              burst_cnt;

  modport master (
    output req, valid, data, fifo_full,
    input  ready, grant, fifo_wr_en, fifo_din, busy, burst_cnt
  );

  modport slave (
    input  req, valid, data, fifo_full,
    output ready, grant, fifo_wr_en, fifo_din, busy, burst_cnt
  );
endinterface
`default_nettype wire

// File: rtl/async_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ producers in the FIFO write-clock domain. The owner
//               keeps the port for up to MAX_BURST words (or until it drops
//               req), then priority rotates to the next index.
// Ports       : clk    - FIFO write clock
//               reset  - synchronous, active-high
//               bus    - slave side of async_fifo_wr_arbiter_if
//                        (req/valid/data/ready per producer, grant, busy,
//                        burst_cnt, fifo_full/fifo_wr_en/fifo_din)
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 20
) (
  input wire                     clk,
  input wire                     reset,
  async_fifo_wr_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [IDX_W-1:0]   owner_q,     owner_d;
  logic [IDX_W-1:0]   prio_ptr_q,  prio_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               busy_q,      busy_d;

  // Round-robin search: first requester at or after prio_ptr, wrapping.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(prio_ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Owner-selected request, valid and data word.
  logic                  owner_req;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;

  always_comb begin
    owner_req   = 1'b0;
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req   = bus.req[i];
        owner_valid = bus.valid[i];
        owner_data  = bus.data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic             xfer;
  logic             accept;
  logic             wr;
  logic [CNT_W-1:0] cnt_inc;
  logic             burst_end;

  assign xfer    = (state_q == S_XFER);
  // A full FIFO withdraws ready, so a word offered in the same cycle waits.
  assign accept  = xfer & owner_req & ~bus.fifo_full;
  assign wr      = accept & owner_valid;
  assign cnt_inc = burst_cnt_q + CNT_W'(1);
  // Dropping req ends the burst; ready is already low, so no write happens.
  assign burst_end = ~owner_req | (wr & (cnt_inc == CNT_LAST));

  assign bus.ready      = accept ? grant_q : '0;
  assign bus.fifo_wr_en = wr;
  assign bus.fifo_din   = xfer ? owner_data : '0;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.burst_cnt  = burst_cnt_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    prio_ptr_d  = prio_ptr_q;
    burst_cnt_d = burst_cnt_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_XFER;
          grant_d     = NUM_REQ'(1) << win_idx;
          owner_d     = win_idx;
          burst_cnt_d = '0;
          busy_d      = 1'b1;
        end
      end
      S_XFER: begin
        if (wr) begin
          burst_cnt_d = cnt_inc;
        end
        // burst_cnt is left at its final value until the next grant.
        if (burst_end) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          busy_d     = 1'b0;
          prio_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      prio_ptr_q  <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      prio_ptr_q  <= prio_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_wr_arbiter
// Description : Self-checking bench for async_fifo_wr_arbiter. A behavioural
//               model (owner index, rotation pointer, word count) predicts
//               every output each cycle; scenario tasks add directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 20;
  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam int CNT_W      = $clog2(MAX_BURST + 1);
  localparam int DW_ALL     = NUM_REQ * DATA_WIDTH;
  localparam int OBS_W      = 2*NUM_REQ + 2 + DATA_WIDTH + CNT_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  async_fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) bus ();

  async_fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owner index (-1 = idle), rotation pointer, words.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  logic [NUM_REQ-1:0]    e_grant = '0, e_ready = '0;
  logic                  e_busy = 1'b0, e_wr = 1'b0;
  logic [DATA_WIDTH-1:0] e_din = '0;
  logic [OBS_W-1:0]      exp_vec = '0;
  wire  [OBS_W-1:0]      obs_vec = {bus.grant, bus.busy, bus.ready, bus.fifo_wr_en,
                                    bus.fifo_din, bus.burst_cnt};

  task automatic model_eval();
    logic [IDX_W-1:0] oi;
    e_grant = '0; e_ready = '0; e_busy = 1'b0; e_wr = 1'b0; e_din = '0;
    if (m_owner >= 0) begin
      oi      = IDX_W'(m_owner);
      e_grant = NUM_REQ'(1) << m_owner;
      e_busy  = 1'b1;
      if (bus.req[oi] && !bus.fifo_full) e_ready = e_grant;
      e_wr    = (e_ready != '0) && bus.valid[oi];
      e_din   = DATA_WIDTH'(bus.data >> (m_owner * DATA_WIDTH));
    end
    exp_vec = {e_grant, e_busy, e_ready, e_wr, e_din, CNT_W'(m_cnt)};
  endtask

  task automatic model_edge();
    logic [IDX_W-1:0] oi;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        oi = IDX_W'((m_ptr + k) % NUM_REQ);
        if (m_owner < 0 && bus.req[oi]) begin
          m_owner = int'(oi);
          m_cnt   = 0;
        end
      end
    end else begin
      oi = IDX_W'(m_owner);
      if (e_wr) m_cnt++;
      if (!bus.req[oi] || (e_wr && m_cnt == MAX_BURST)) begin
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0; bus.valid = '0; bus.data = '0; bus.fifo_full = 1'b0;
    model_eval();
    advance();
    reset = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.req = NUM_REQ'($urandom); bus.valid = NUM_REQ'($urandom);
    bus.data = DW_ALL'($urandom); bus.fifo_full = 1'b0;
    model_eval();
    advance();
    @(negedge clk);
    model_eval();
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_bad++; $display("FAIL reset_model: got %h expected %h", obs_vec, exp_vec);
    end
    n_cmp++;
    if (obs_vec !== OBS_W'(0)) begin
      n_bad++; $display("FAIL reset_zero: got %h expected 0", obs_vec);
    end
    advance();
    reset = 1'b0;
  endtask

  task automatic test_single();
    int wcount = 0;
    do_reset();
    bus.req = 4'b0100; bus.valid = 4'b0100;
    bus.data[2*DATA_WIDTH +: DATA_WIDTH] = '0;
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL single c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 1 || c == 22) begin
        n_cmp++;
        if (bus.grant !== 4'b0100) begin
          n_bad++; $display("FAIL single_grant c%0d: got %b expected 0100", c, bus.grant);
        end
      end
      if (c == 21) begin
        n_cmp++;
        if (bus.grant !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin
          n_bad++; $display("FAIL single_gap: grant %b wr %b expected 0000/0", bus.grant, bus.fifo_wr_en);
        end
      end
      if (bus.fifo_wr_en === 1'b1) begin
        n_cmp++;
        if (bus.fifo_din !== DATA_WIDTH'(wcount)) begin
          n_bad++; $display("FAIL single_din: got %h expected %h", bus.fifo_din, DATA_WIDTH'(wcount));
        end
        wcount++;
      end
      advance();
      bus.data[2*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(wcount);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int wcnt[$];
    int w = 0;
    logic [NUM_REQ-1:0] prev = '0;
    do_reset();
    bus.req = '1; bus.valid = '1;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      bus.data = DW_ALL'($urandom);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL rr c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.fifo_wr_en === 1'b1) w++;
      if (prev == '0 && bus.grant != '0) order.push_back(onehot_idx(bus.grant));
      if (prev != '0 && bus.grant == '0) begin wcnt.push_back(w); w = 0; end
      prev = bus.grant;
      advance();
    end
    n_cmp++;
    if (order.size() != 5 || wcnt.size() != 4) begin
      n_bad++; $display("FAIL rr_timeout: grants %0d bursts %0d expected 5/4", order.size(), wcnt.size());
    end
    foreach (order[i]) begin
      n_cmp++;
      if (order[i] != i % NUM_REQ) begin
        n_bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % NUM_REQ);
      end
    end
    foreach (wcnt[i]) begin
      n_cmp++;
      if (wcnt[i] != MAX_BURST) begin
        n_bad++; $display("FAIL rr_words[%0d]: got %0d expected %0d", i, wcnt[i], MAX_BURST);
      end
    end
  endtask

  task automatic test_full_stall();
    int w = 0;
    int stall_n = 0;
    bit ended = 1'b0;
    logic [NUM_REQ-1:0] prev = '0;
    do_reset();
    bus.req = 4'b0010; bus.valid = 4'b0010;
    for (int c = 0; c < 60 && !ended; c++) begin
      bus.fifo_full = (w == 7 && stall_n < 5);
      bus.data = DW_ALL'($urandom);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL stall c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.fifo_full) begin
        stall_n++;
        n_cmp++;
        if (bus.ready !== '0 || bus.fifo_wr_en !== 1'b0 || bus.burst_cnt !== CNT_W'(7)) begin
          n_bad++; $display("FAIL stall_hold: ready %b wr %b cnt %0d expected 0/0/7",
                            bus.ready, bus.fifo_wr_en, bus.burst_cnt);
        end
      end
      if (bus.fifo_wr_en === 1'b1) w++;
      if (prev != '0 && bus.grant == '0) begin
        ended = 1'b1;
        n_cmp++;
        if (w != MAX_BURST || bus.burst_cnt !== CNT_W'(MAX_BURST)) begin
          n_bad++; $display("FAIL stall_end: writes %0d cnt %0d expected %0d", w, bus.burst_cnt, MAX_BURST);
        end
      end
      prev = bus.grant;
      advance();
    end
    n_cmp++;
    if (!ended || stall_n != 5) begin
      n_bad++; $display("FAIL stall_timeout: ended %0d stalls %0d expected 1/5", ended, stall_n);
    end
  endtask

  task automatic test_release();
    int w = 0;
    int phase = 0;
    logic [NUM_REQ-1:0] prev = '0;
    do_reset();
    bus.valid = '1;
    for (int c = 0; c < 30 && phase < 2; c++) begin
      bus.req  = (w >= 3) ? 4'b1001 : 4'b0010;
      bus.data = DW_ALL'($urandom);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL release c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.fifo_wr_en === 1'b1) w++;
      if (phase == 0 && prev != '0 && bus.grant == '0) begin
        phase = 1;
        n_cmp++;
        if (bus.burst_cnt !== CNT_W'(3)) begin
          n_bad++; $display("FAIL release_cnt: got %0d expected 3", bus.burst_cnt);
        end
      end else if (phase == 1 && bus.grant != '0) begin
        phase = 2;
        n_cmp++;
        if (bus.grant !== 4'b1000) begin
          n_bad++; $display("FAIL release_next: got %b expected 1000", bus.grant);
        end
      end
      prev = bus.grant;
      advance();
    end
    n_cmp++;
    if (phase != 2) begin
      n_bad++; $display("FAIL release_timeout: phase %0d expected 2", phase);
    end
  endtask

  task automatic test_valid_toggle();
    int w = 0;
    int g_cyc = 0;
    bit ended = 1'b0;
    logic [NUM_REQ-1:0] prev = '0;
    do_reset();
    bus.req = 4'b0001;
    for (int c = 0; c < 80 && !ended; c++) begin
      bus.valid = (c % 2 == 1) ? 4'b0001 : 4'b0000;
      bus.data  = DW_ALL'($urandom);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL toggle c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.fifo_wr_en === 1'b1) w++;
      if (bus.grant != '0) g_cyc++;
      if (prev != '0 && bus.grant == '0) begin
        ended = 1'b1;
        n_cmp++;
        if (w != MAX_BURST || g_cyc != 2*MAX_BURST - 1) begin
          n_bad++; $display("FAIL toggle_end: writes %0d cycles %0d expected %0d/%0d",
                            w, g_cyc, MAX_BURST, 2*MAX_BURST - 1);
        end
      end
      prev = bus.grant;
      advance();
    end
    n_cmp++;
    if (!ended) begin
      n_bad++; $display("FAIL toggle_timeout: burst did not end");
    end
  endtask

  task automatic test_reset_mid_burst();
    int w = 0;
    int phase = 0;
    do_reset();
    bus.req = 4'b0100; bus.valid = 4'b0100;
    for (int c = 0; c < 40 && phase < 4; c++) begin
      if (phase == 0 && w == 9) begin
        reset = 1'b1; phase = 1;
      end else if (phase == 1) begin
        reset = 1'b0; bus.req = 4'b1001; bus.valid = 4'b1001; phase = 2;
      end else if (phase == 2) begin
        phase = 3;
      end
      bus.data = DW_ALL'($urandom);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL rstmid c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.fifo_wr_en === 1'b1) w++;
      if (phase == 2) begin
        n_cmp++;
        if (bus.grant !== '0 || bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
          n_bad++; $display("FAIL rstmid_abort: grant %b wr %b busy %b expected 0/0/0",
                            bus.grant, bus.fifo_wr_en, bus.busy);
        end
      end else if (phase == 3) begin
        phase = 4;
        n_cmp++;
        if (bus.grant !== 4'b0001) begin
          n_bad++; $display("FAIL rstmid_regrant: got %b expected 0001", bus.grant);
        end
      end
      advance();
    end
    reset = 1'b0;
    n_cmp++;
    if (phase != 4) begin
      n_bad++; $display("FAIL rstmid_timeout: phase %0d expected 4", phase);
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] held = '0;
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(0, 7) == 0) held[i] = ~held[i];
      bus.req       = held;
      bus.valid     = NUM_REQ'($urandom);
      bus.data      = DW_ALL'($urandom);
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL random c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      n_cmp++;
      if (!$onehot0(bus.grant)) begin
        n_bad++; $display("FAIL random_onehot c%0d: got %b expected one-hot or zero", c, bus.grant);
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.valid = '0; bus.data = '0; bus.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_release();
    test_valid_toggle();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
